// File: rtl/cntseq_pkg.sv
// cntseq_pkg: shared state encoding and default widths for counter_sequencer
package cntseq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
  localparam int CNTSEQ_W = 4;
  localparam int CNTSEQ_RW = 4;
endpackage

// File: rtl/sync_counter_w.sv
// sync_counter_w: loadable synchronous up-counter, priority mr > load > en, co = en at all-ones
module sync_counter_w #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         mr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         co
);
  always_ff @(posedge clk)
    q <= mr ? '0 : load ? d : en ? q + 1'b1 : q;
  assign co = en & (&q);
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: start/busy/done interval timer over sync_counter_w; CNTSEQ_REPEAT_EN adds reps/rep counter
module counter_sequencer
  import cntseq_pkg::*;
#(
  parameter int W = CNTSEQ_W
`ifdef CNTSEQ_REPEAT_EN
  , parameter int RW = CNTSEQ_RW
`endif
) (
  input  logic          clk,
  input  logic          mr,
  input  logic          start,
  input  logic [W-1:0]  preset,
`ifdef CNTSEQ_REPEAT_EN
  input  logic [RW-1:0] reps,
`endif
  input  logic          pause,
  output logic          busy,
  output logic          done,
  output logic          tick,
  output logic [W-1:0]  q
);
  state_t state, state_next;
  logic [W-1:0] preset_q;
  logic load, en, co, rep_nz, accept, reload;
  assign accept = (state == IDLE) & start;
  assign reload = (state == RUN) & co & rep_nz;
  always_ff @(posedge clk)
    state <= mr ? IDLE : state_next;
  always_comb
    state_next = (state == IDLE) ? (start ? LOAD : IDLE) :
                 (state == LOAD) ? RUN :
                 (state == RUN)  ? ((co & ~rep_nz) ? DONE : RUN) : IDLE;
  always_comb begin
    en   = (state == RUN) & ~pause;
    load = (state == LOAD) | reload;
    busy = (state == LOAD) | (state == RUN);
    done = (state == DONE);
  end
  always_ff @(posedge clk) begin
    preset_q <= mr ? '0 : accept ? preset : preset_q;
    tick     <= ~mr & co;
  end
`ifdef CNTSEQ_REPEAT_EN
  logic [RW-1:0] rep_cnt;
  always_ff @(posedge clk)
    rep_cnt <= mr ? '0 : accept ? reps : reload ? rep_cnt - 1'b1 : rep_cnt;
  assign rep_nz = |rep_cnt;
`else
  assign rep_nz = 1'b0;
`endif
  sync_counter_w #(.W(W)) u_cnt (
    .clk (clk),
    .mr  (mr),
    .load(load),
    .en  (en),
    .d   (preset_q),
    .q   (q),
    .co  (co)
  );
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: vector table, hand sequences and randomized runs against an interval-level model
module tb_counter_sequencer;
  localparam int W = 4;
  localparam int RW = 4;
  localparam int MAX = 15;
  logic clk = 1'b0;
  logic mr = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic [W-1:0] preset = '0;
`ifdef CNTSEQ_REPEAT_EN
  logic [RW-1:0] reps = '0;
`endif
  logic busy, done, tick;
  logic [W-1:0] q;
  int checks = 0;
  int failures = 0;

  counter_sequencer dut (
    .clk   (clk),
    .mr    (mr),
    .start (start),
    .preset(preset),
`ifdef CNTSEQ_REPEAT_EN
    .reps  (reps),
`endif
    .pause (pause),
    .busy  (busy),
    .done  (done),
    .tick  (tick),
    .q     (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int r;
    int pq;
    int pl;
    int exp_edge;
    int exp_ticks;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reps(input int r);
`ifdef CNTSEQ_REPEAT_EN
    reps = RW'(r);
`endif
  endtask

  function automatic int eff_reps(input int r);
`ifdef CNTSEQ_REPEAT_EN
    return r;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] outs(input int v, input bit b, input bit d, input bit t);
    return {25'd0, W'(v), b, d, t};
  endfunction

  // Table run: count edges from start acceptance (edge 0) to the done cycle.
  task automatic run_tbl(input vec_t t, input int idx);
    int e, ticks, pleft;
    bit started, seen;
    preset = W'(t.p);
    set_reps(t.r);
    start = 1'b1;
    step();
    start = 1'b0;
    e = 0; ticks = 0; pleft = 0; started = 0; seen = 0;
    while (e < 100 && !seen) begin
      if (!started && int'(q) == t.pq) begin
        pleft = t.pl;
        started = 1;
      end
      pause = (pleft > 0);
      if (pleft > 0) pleft--;
      step();
      e++;
      if (tick === 1'b1) ticks++;
      seen = (done === 1'b1);
    end
    pause = 1'b0;
    chk($sformatf("vec%0d_done_edge", idx), e, t.exp_edge);
    chk($sformatf("vec%0d_ticks", idx), ticks, t.exp_ticks);
    chk($sformatf("vec%0d_done_cycle", idx), {q, busy, done, tick}, outs(0, 0, 1, 1));
    step();
    chk($sformatf("vec%0d_idle", idx), {q, busy, done, tick}, outs(0, 0, 0, 0));
  endtask

  // Randomized run checked cycle by cycle against an interval-level walk of the schedule.
  task automatic run_rand(input int p, input int r, input int pct);
    int v, itv, re, guard;
    bit tk, fin, pz;
    re = eff_reps(r);
    preset = W'(p);
    set_reps(r);
    start = 1'b1;
    step();
    start = 1'b0;
    preset = W'($urandom);
    set_reps(int'($urandom));
    chk("rand_load", {q, busy, done, tick}, outs(0, 1, 0, 0));
    pause = 1'(($urandom));
    step();
    v = p; itv = 0; tk = 0; fin = 0; guard = 0;
    while (!fin && guard < 2000) begin
      chk("rand_run", {q, busy, done, tick}, outs(v, 1, 0, tk));
      tk = 0;
      pz = ($urandom_range(99) < pct);
      pause = pz;
      start = 1'($urandom);
      preset = W'($urandom);
      if (!pz) begin
        if (v == MAX) begin
          if (itv < re) begin
            v = p;
            itv++;
            tk = 1;
          end else fin = 1;
        end else v++;
      end
      step();
      guard++;
    end
    if (!fin) chk("rand_guard", guard, 0);
    start = 1'b0;
    pause = 1'($urandom);
    chk("rand_done", {q, busy, done, tick}, outs(0, 0, 1, 1));
    step();
    pause = 1'b0;
    chk("rand_idle", {q, busy, done, tick}, outs(0, 0, 0, 0));
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{p: 12, r: 0, pq: -1, pl: 0, exp_edge: 5, exp_ticks: 1};
    tbl[1] = '{p: 15, r: 0, pq: -1, pl: 0, exp_edge: 2, exp_ticks: 1};
    tbl[2] = '{p: 0, r: 0, pq: -1, pl: 0, exp_edge: 17, exp_ticks: 1};
    tbl[3] = '{p: 12, r: 0, pq: 13, pl: 3, exp_edge: 8, exp_ticks: 1};
`ifdef CNTSEQ_REPEAT_EN
    tbl[4] = '{p: 14, r: 2, pq: -1, pl: 0, exp_edge: 7, exp_ticks: 3};
`else
    tbl[4] = '{p: 14, r: 2, pq: -1, pl: 0, exp_edge: 3, exp_ticks: 1};
`endif
    step();
    step();
    mr = 1'b0;
    chk("reset", {q, busy, done, tick}, outs(0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_quiet", {q, busy, done, tick}, outs(0, 0, 0, 0));
    end
    for (int i = 0; i < 5; i++) run_tbl(tbl[i], i);
    // start asserted only in the DONE cycle must not launch a new run
    preset = 4'd15;
    set_reps(0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("done_seen", {q, busy, done, tick}, outs(0, 0, 1, 1));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_done_1", {q, busy, done, tick}, outs(0, 0, 0, 0));
    step();
    chk("start_in_done_2", {q, busy, done, tick}, outs(0, 0, 0, 0));
    // mr while q=14 in RUN aborts without done or tick
    preset = 4'd12;
    set_reps(3);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && q !== 4'd14; i++) step();
    chk("mr_pre", {q, busy}, {25'd0, 4'd14, 1'b1} >> 0);
    mr = 1'b1;
    step();
    mr = 1'b0;
    chk("mr_abort", {q, busy, done, tick}, outs(0, 0, 0, 0));
    step();
    chk("mr_after", {q, busy, done, tick}, outs(0, 0, 0, 0));
    for (int i = 0; i < 25; i++)
      run_rand(int'($urandom_range(15)), int'($urandom_range(3)), int'($urandom_range(40)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Interval-timer controller that sequences a loadable synchronous binary counter. It runs the counter from a preset value to terminal count, optionally for a programmed number of repeat intervals, and reports progress over a start/busy/done handshake. It sits between control logic and a counter datapath of the loadable-counter family (mr/load/en/d/q/co). It turns one start request into correctly timed load and enable strobes.

## Interface
- W, 4, counter width; terminal count is 2^W-1
- RW, 4, repeat-count width (present only with CNTSEQ_REPEAT_EN)
- clk  in  1  clock; all state changes on the rising edge
- mr  in  1  reset: one clock, synchronous, active-high (mr=1 sampled on a clk rising edge resets the block)
- start  in  1  request; sampled only in IDLE
- preset  in  W  counter start value; latched when start is accepted
- reps  in  RW  extra intervals after the first; latched with preset (only with CNTSEQ_REPEAT_EN)
- pause  in  1  while high in RUN, counting freezes
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse in DONE
- tick  out  1  registered one-cycle pulse after each interval's terminal edge
- q  out  W  live counter value

## Operation
- Reset: state=IDLE, q=0, busy=0, done=0, tick=0, latched preset/reps=0. mr overrides all other inputs.
- FSM states:
  - IDLE
    - start=1: latch preset and reps, go to LOAD.
    - Otherwise stay in IDLE.
  - LOAD
    - Counter load=1 for one cycle, so q becomes preset.
    - Go to RUN.
  - RUN
    - Counter en = ~pause.
    - Terminal event = en & (q == 2^W-1), which is the counter's co.
    - Terminal event with remaining reps > 0: counter load=1 with the latched preset. load has priority over en, so q goes from max to preset. Decrement the rep count and stay in RUN.
    - Terminal event with remaining reps == 0: the counter increments and wraps, so q becomes 0. Go to DONE.
  - DONE
    - done=1 for one cycle, then go to IDLE.
- start is ignored outside IDLE. This includes the DONE cycle. A new request needs start held or re-asserted in IDLE.
- Each interval is (2^W - preset) enabled RUN cycles. preset = 2^W-1 gives one cycle per interval. preset = 0 gives 2^W cycles.
- pause stretches an interval without losing its count. pause in LOAD, IDLE or DONE has no effect.
- mr mid-operation: the next edge forces IDLE and q=0. No done or tick pulse is produced.

## Timing
- Edge 0: start sampled in IDLE.
- Edge 1: q=preset and busy=1. busy also covers the LOAD cycle, so busy is high from just after edge 0.
- Without pause, the final terminal edge is at 1 + (reps+1)(2^W - preset).
  - State becomes DONE at that edge: done=1 and tick=1 in the same cycle, busy=0.
  - One edge later: IDLE, and done=0, tick=0.
- A tick for a non-final interval is high for the cycle in which q=preset after the reload.
- Latency from start to done, without pause: 1 + (reps+1)(2^W - preset) cycles.
- All outputs are registered or pure state decodes. No combinational path from an input to busy, done or tick.

## Configuration
- CNTSEQ_REPEAT_EN defined:
  - The reps port and rep counter exist.
  - Reload-on-terminal behaves as described above.
- CNTSEQ_REPEAT_EN undefined:
  - No reps port and no rep counter. Remaining reps is treated as 0.
  - Every run is exactly one interval, and the first terminal event goes to DONE.

## Structure
- Package cntseq_pkg holds:
  - the state typedef: IDLE, LOAD, RUN, DONE, 2-bit encoding;
  - default widths CNTSEQ_W=4 and CNTSEQ_RW=4.
- One sub-module, sync_counter_w (parameter W), with ports mr, load, en, clk, d, q, co.
  - mr is synchronous, active-high, and clears q to 0.
  - Priority order: mr, then load, then en (increment).
  - co = en & (q == all-ones), combinational.
- The top level holds:
  - the FSM;
  - the preset register;
  - the rep counter;
  - the tick register.

## Test plan
- Reset: mr=1 for 2 cycles, then 0 -> q=0, busy=0, done=0, tick=0. No activity without start.
- Single interval: preset=12, reps=0, start pulse at edge 0 -> q = 12, 13, 14, 15 on edges 1–4; done=1 and tick=1 after edge 5; q=0; IDLE after edge 6.
- Repeats (macro on): preset=14, reps=2 -> q sequence 14, 15, 14, 15, 14, 15; three tick pulses; done after edge 7.
- Pause: preset=12, pause high for 3 cycles when q=13 -> q holds at 13 for those 3 cycles; done is delayed to after edge 8.
- Boundaries:
  - preset=15, reps=0 -> done after edge 2.
  - preset=0 -> done after edge 17.
  - start during RUN or DONE -> ignored.
- Reset mid-run: mr=1 while q=14 in RUN -> next edge gives IDLE and q=0. No done or tick; busy=0.
